countdown_timer: RTL

Keypad-loaded MM:SS BCD countdown timer for the microwave control path. Accepts digit entry while the magnetron is off and decrements once per second while `mag_on` is high. It produces the `timer_done` level consumed by the start/stop control logic, which forces latch reset when `timer_done` is high. It also drives the four BCD digits to the display stage.

---
 rtl/countdown_timer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// countdown_timer
//   MM:SS BCD countdown timer for the microwave control path. Digits are
//   shifted in from the keypad while the magnetron is off; while mag_on is
//   high the count decrements once every TICKS_PER_SEC clocks. timer_done is
//   high whenever the registered count is 00:00.
//
//   Optional feature macro: COUNTDOWN_ADD30_EN (adds the add30 strobe port).
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   clearn     in   active-low front-panel clear
//   mag_on     in   magnetron on; enables counting
//   key_valid  in   single-cycle keypress strobe
//   key_digit  in   [3:0] BCD key value (10..15 ignored)
//   min_tens   out  [3:0] count digit
//   min_ones   out  [3:0] count digit
//   sec_tens   out  [3:0] count digit (may hold 6..9, no normalisation)
//   sec_ones   out  [3:0] count digit
//   timer_done out  high when count is 00:00
//   add30      in   single-cycle +30 s strobe (COUNTDOWN_ADD30_EN only)
module countdown_timer #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clearn,
    input  logic       mag_on,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done
`ifdef COUNTDOWN_ADD30_EN
    ,
    input  logic       add30
`endif
);

    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

    logic [15:0]   count;
    logic [15:0]   count_next;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_next;
    logic          done_next;
    logic          tick;
    logic          key_ok;
    logic          add_req;
    state_t        state;

    // BCD decrement with borrow; sec_tens borrows to 5 so a minute is 60 s.
    // Caller guarantees a nonzero count.
    function automatic logic [15:0] bcd_dec(input logic [15:0] c);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = c;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

`ifdef COUNTDOWN_ADD30_EN
    // +30 s: sec_tens >= 3 wraps down by 3 and carries a minute; a carry
    // past 99 minutes saturates the whole count at 99:59.
    function automatic logic [15:0] bcd_add30(input logic [15:0] c);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = c;
        if (st >= 4'd3) begin
            st = st - 4'd3;
            if (mo != 4'd9) begin
                mo = mo + 4'd1;
            end else if (mt != 4'd9) begin
                mo = 4'd0;
                mt = mt + 4'd1;
            end else begin
                mt = 4'd9;
                mo = 4'd9;
                st = 4'd5;
                so = 4'd9;
            end
        end else begin
            st = st + 4'd3;
        end
        return {mt, mo, st, so};
    endfunction

    assign add_req = add30;
`else
    assign add_req = 1'b0;
`endif

    // State is a pure function of the count and mag_on; the count register
    // itself is the state storage.
    always_comb begin
        if (count == '0) begin
            state = EXPIRED;
        end else if (mag_on) begin
            state = RUN;
        end else begin
            state = IDLE;
        end
    end

    always_comb begin
        tick       = 1'b0;
        presc_next = presc;
        count_next = count;
        key_ok     = key_valid && !mag_on && (key_digit <= 4'd9);

        if (state == RUN) begin
            if (presc == PRESC_MAX) begin
                presc_next = '0;
                tick       = 1'b1;
            end else begin
                presc_next = presc + 1'b1;
            end
        end

        if (tick) begin
            count_next = bcd_dec(count);
        end

`ifdef COUNTDOWN_ADD30_EN
        if (add_req) begin
            count_next = bcd_add30(count_next);
        end else
`endif
        // add30 outranks key entry; key and tick never coexist (mag_on).
        if (key_ok && !add_req) begin
            count_next = {count[11:0], key_digit};
            presc_next = '0;
        end

        done_next = (count_next == '0);
    end

    always_ff @(posedge clk) begin
        if (reset || !clearn) begin
            count      <= '0;
            presc      <= '0;
            timer_done <= 1'b1;
        end else begin
            count      <= count_next;
            presc      <= presc_next;
            timer_done <= done_next;
        end
    end

    assign min_tens = count[15:12];
    assign min_ones = count[11:8];
    assign sec_tens = count[7:4];
    assign sec_ones = count[3:0];

endmodule
